// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM encoding and byte-lane constants.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_BUSY = 2'd1,
        I_BUSY = 2'd2
    } arb_state_e;

    // Byte enables are active low.
    localparam logic [3:0]  SEL_NONE  = 4'b1111;
    localparam logic [3:0]  SEL_WORD  = 4'b0000;
    localparam logic [31:0] WORD_ZERO = 32'h0000_0000;

endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// Bus transaction watchdog: counts wait cycles without bus_ack and flags expiry at TIMEOUT-1.
module mem_bus_arbiter_watchdog #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start_i,
    input  logic active_i,
    input  logic ack_i,
    output logic expire_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire_o = active_i && !ack_i && (cnt_q == CNT_LAST);

    // Next count: restart on a new transaction or any termination, else count wait cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i || ack_i || expire_o) begin
            cnt_d = '0;
        end else if (active_i) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the external memory port between instruction fetch and the data path (data first),
// holds the registered request until bus_ack or watchdog abort, and returns results to the owner.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_ce,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_ce,
    input  logic        d_we,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        bus_ce,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_err,
    output logic        stall_req,
    output logic        grant_d
);

    arb_state_e  state_q, state_d;
    logic        bus_ce_q, bus_ce_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        if_ready_q, if_ready_d;
    logic        d_ready_q, d_ready_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        bus_err_q, bus_err_d;
    logic        grant_d_q, grant_d_d;
    logic        start_s;
    logic        busy_s;
    logic        expire_s;
    logic [31:0] result_s;

    assign busy_s   = (state_q == D_BUSY) || (state_q == I_BUSY);
    assign result_s = bus_ack ? bus_rdata : WORD_ZERO;

    mem_bus_arbiter_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk      (clk),
        .reset_n  (reset_n),
        .start_i  (start_s),
        .active_i (busy_s),
        .ack_i    (bus_ack),
        .expire_o (expire_s)
    );

    // Next-state and registered-output logic for the arbitration FSM.
    always_comb begin
        state_d     = state_q;
        bus_ce_d    = bus_ce_q;
        bus_we_d    = bus_we_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        bus_err_d   = 1'b0;
        start_s     = 1'b0;
        case (state_q)
            IDLE: begin
                // A requester whose ready is pulsing still shows its old ce; do not reissue it.
                if (d_ce && !d_ready_q) begin
                    state_d     = D_BUSY;
                    start_s     = 1'b1;
                    bus_ce_d    = 1'b1;
                    bus_we_d    = d_we;
                    bus_sel_d   = d_sel;
                    bus_addr_d  = d_addr;
                    bus_wdata_d = d_wdata;
                end else if (if_ce && !if_ready_q) begin
                    state_d     = I_BUSY;
                    start_s     = 1'b1;
                    bus_ce_d    = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_sel_d   = SEL_WORD;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = WORD_ZERO;
                end else begin
                    state_d = IDLE;
                end
            end
            D_BUSY, I_BUSY: begin
                if (bus_ack || expire_s) begin
                    state_d   = IDLE;
                    bus_ce_d  = 1'b0;
                    bus_we_d  = 1'b0;
                    bus_sel_d = SEL_NONE;
                    bus_err_d = expire_s;
                    if (state_q == D_BUSY) begin
                        d_ready_d = 1'b1;
                        // A completed store leaves load data untouched; an abort always clears it.
                        if (!bus_we_q || expire_s) begin
                            d_rdata_d = result_s;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = result_s;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d   = IDLE;
                bus_ce_d  = 1'b0;
                bus_we_d  = 1'b0;
                bus_sel_d = SEL_NONE;
            end
        endcase
        grant_d_d = (state_d == D_BUSY);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bus_ce_q    <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= SEL_NONE;
            bus_addr_q  <= WORD_ZERO;
            bus_wdata_q <= WORD_ZERO;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            if_rdata_q  <= WORD_ZERO;
            d_rdata_q   <= WORD_ZERO;
            bus_err_q   <= 1'b0;
            grant_d_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_ce_q    <= bus_ce_d;
            bus_we_q    <= bus_we_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            bus_err_q   <= bus_err_d;
            grant_d_q   <= grant_d_d;
        end
    end

    assign bus_ce    = bus_ce_q;
    assign bus_we    = bus_we_q;
    assign bus_sel   = bus_sel_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign if_ready  = if_ready_q;
    assign d_ready   = d_ready_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign bus_err   = bus_err_q;
    assign grant_d   = grant_d_q;
    assign stall_req = (d_ce && !d_ready_q) || (if_ce && !if_ready_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: per-cycle vector table plus watchdog and reset sequences.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_ce;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_ce;
    logic        d_we;
    logic [3:0]  d_sel;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        bus_ce;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;
    logic        stall_req;
    logic        grant_d;

    int checks;
    int errors;

    typedef struct {
        logic        if_ce;
        logic [31:0] if_addr;
        logic        d_ce;
        logic        d_we;
        logic [3:0]  d_sel;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        ack;
        logic [31:0] rdata;
        logic        e_bus_ce;
        logic        e_bus_we;
        logic [3:0]  e_bus_sel;
        logic [31:0] e_bus_addr;
        logic [31:0] e_bus_wdata;
        logic        e_if_ready;
        logic [31:0] e_if_rdata;
        logic        e_d_ready;
        logic [31:0] e_d_rdata;
        logic        e_bus_err;
        logic        e_grant;
        logic        e_stall;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vec [NVEC];

    mem_bus_arbiter #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .if_ce     (if_ce),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .d_ce      (d_ce),
        .d_we      (d_we),
        .d_sel     (d_sel),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .bus_ce    (bus_ce),
        .bus_we    (bus_we),
        .bus_sel   (bus_sel),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .bus_err   (bus_err),
        .stall_req (stall_req),
        .grant_d   (grant_d)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        if_ce     = v.if_ce;
        if_addr   = v.if_addr;
        d_ce      = v.d_ce;
        d_we      = v.d_we;
        d_sel     = v.d_sel;
        d_addr    = v.d_addr;
        d_wdata   = v.d_wdata;
        bus_ack   = v.ack;
        bus_rdata = v.rdata;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        check($sformatf("v%0d bus_ce", i),    32'(bus_ce),    32'(v.e_bus_ce));
        check($sformatf("v%0d bus_we", i),    32'(bus_we),    32'(v.e_bus_we));
        check($sformatf("v%0d bus_sel", i),   32'(bus_sel),   32'(v.e_bus_sel));
        check($sformatf("v%0d bus_addr", i),  bus_addr,       v.e_bus_addr);
        check($sformatf("v%0d bus_wdata", i), bus_wdata,      v.e_bus_wdata);
        check($sformatf("v%0d if_ready", i),  32'(if_ready),  32'(v.e_if_ready));
        check($sformatf("v%0d if_rdata", i),  if_rdata,       v.e_if_rdata);
        check($sformatf("v%0d d_ready", i),   32'(d_ready),   32'(v.e_d_ready));
        check($sformatf("v%0d d_rdata", i),   d_rdata,        v.e_d_rdata);
        check($sformatf("v%0d bus_err", i),   32'(bus_err),   32'(v.e_bus_err));
        check($sformatf("v%0d grant_d", i),   32'(grant_d),   32'(v.e_grant));
        check($sformatf("v%0d stall_req", i), 32'(stall_req), 32'(v.e_stall));
    endtask

    task automatic check_reset(input string tag);
        check({tag, " bus_ce"},    32'(bus_ce),    32'd0);
        check({tag, " bus_we"},    32'(bus_we),    32'd0);
        check({tag, " bus_sel"},   32'(bus_sel),   32'hF);
        check({tag, " bus_addr"},  bus_addr,       32'h0);
        check({tag, " bus_wdata"}, bus_wdata,      32'h0);
        check({tag, " if_ready"},  32'(if_ready),  32'd0);
        check({tag, " d_ready"},   32'(d_ready),   32'd0);
        check({tag, " if_rdata"},  if_rdata,       32'h0);
        check({tag, " d_rdata"},   d_rdata,        32'h0);
        check({tag, " bus_err"},   32'(bus_err),   32'd0);
        check({tag, " grant_d"},   32'(grant_d),   32'd0);
    endtask

    initial begin
        int n;
        logic fired;
        checks = 0;
        errors = 0;

        //           if_ce  if_addr      d_ce  d_we  d_sel    d_addr       d_wdata       ack   rdata          | bce   bwe   bsel     baddr        bwdata        ifr   if_rdata       dr    d_rdata        err   gnt   stall
        vec[0]  = '{1'b0, 32'h0,       1'b1, 1'b0, 4'b0000, 32'h100,     32'h0,        1'b0, 32'h0,         1'b1, 1'b0, 4'b0000, 32'h100,     32'h0,        1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b1};
        vec[1]  = '{1'b0, 32'h0,       1'b1, 1'b0, 4'b0000, 32'h100,     32'h0,        1'b0, 32'h0,         1'b1, 1'b0, 4'b0000, 32'h100,     32'h0,        1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b1};
        vec[2]  = '{1'b0, 32'h0,       1'b1, 1'b0, 4'b0000, 32'h100,     32'h0,        1'b0, 32'h0,         1'b1, 1'b0, 4'b0000, 32'h100,     32'h0,        1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b1};
        vec[3]  = '{1'b0, 32'h0,       1'b1, 1'b0, 4'b0000, 32'h100,     32'h0,        1'b1, 32'hDEADBEEF,  1'b0, 1'b0, 4'b1111, 32'h100,     32'h0,        1'b0, 32'h0,         1'b1, 32'hDEADBEEF,  1'b0, 1'b0, 1'b0};
        vec[4]  = '{1'b0, 32'h0,       1'b1, 1'b0, 4'b0000, 32'h100,     32'h0,        1'b0, 32'h0,         1'b0, 1'b0, 4'b1111, 32'h100,     32'h0,        1'b0, 32'h0,         1'b0, 32'hDEADBEEF,  1'b0, 1'b0, 1'b1};
        vec[5]  = '{1'b1, 32'h0,       1'b1, 1'b1, 4'b1011, 32'h201,     32'h5A5A5A5A, 1'b0, 32'h0,         1'b1, 1'b1, 4'b1011, 32'h201,     32'h5A5A5A5A, 1'b0, 32'h0,         1'b0, 32'hDEADBEEF,  1'b0, 1'b1, 1'b1};
        vec[6]  = '{1'b1, 32'h0,       1'b1, 1'b1, 4'b1011, 32'h201,     32'h5A5A5A5A, 1'b1, 32'h12345678,  1'b0, 1'b0, 4'b1111, 32'h201,     32'h5A5A5A5A, 1'b0, 32'h0,         1'b1, 32'hDEADBEEF,  1'b0, 1'b0, 1'b1};
        vec[7]  = '{1'b1, 32'h0,       1'b1, 1'b1, 4'b1011, 32'h201,     32'h5A5A5A5A, 1'b0, 32'h0,         1'b1, 1'b0, 4'b0000, 32'h0,       32'h0,        1'b0, 32'h0,         1'b0, 32'hDEADBEEF,  1'b0, 1'b0, 1'b1};
        vec[8]  = '{1'b1, 32'h0,       1'b0, 1'b0, 4'b1111, 32'h0,       32'h0,        1'b1, 32'h00000013,  1'b0, 1'b0, 4'b1111, 32'h0,       32'h0,        1'b1, 32'h00000013,  1'b0, 32'hDEADBEEF,  1'b0, 1'b0, 1'b0};
        vec[9]  = '{1'b1, 32'h0,       1'b0, 1'b0, 4'b1111, 32'h0,       32'h0,        1'b0, 32'h0,         1'b0, 1'b0, 4'b1111, 32'h0,       32'h0,        1'b0, 32'h00000013,  1'b0, 32'hDEADBEEF,  1'b0, 1'b0, 1'b1};
        vec[10] = '{1'b1, 32'h4,       1'b0, 1'b0, 4'b1111, 32'h0,       32'h0,        1'b0, 32'h0,         1'b1, 1'b0, 4'b0000, 32'h4,       32'h0,        1'b0, 32'h00000013,  1'b0, 32'hDEADBEEF,  1'b0, 1'b0, 1'b1};
        vec[11] = '{1'b1, 32'h4,       1'b0, 1'b0, 4'b1111, 32'h0,       32'h0,        1'b1, 32'hAABBCCDD,  1'b0, 1'b0, 4'b1111, 32'h4,       32'h0,        1'b1, 32'hAABBCCDD,  1'b0, 32'hDEADBEEF,  1'b0, 1'b0, 1'b0};
        vec[12] = '{1'b1, 32'h4,       1'b0, 1'b0, 4'b1111, 32'h0,       32'h0,        1'b0, 32'h0,         1'b0, 1'b0, 4'b1111, 32'h4,       32'h0,        1'b0, 32'hAABBCCDD,  1'b0, 32'hDEADBEEF,  1'b0, 1'b0, 1'b1};
        vec[13] = '{1'b0, 32'h0,       1'b0, 1'b0, 4'b1111, 32'h0,       32'h0,        1'b1, 32'hFFFFFFFF,  1'b0, 1'b0, 4'b1111, 32'h4,       32'h0,        1'b0, 32'hAABBCCDD,  1'b0, 32'hDEADBEEF,  1'b0, 1'b0, 1'b0};
        vec[14] = '{1'b0, 32'h0,       1'b0, 1'b0, 4'b1111, 32'h0,       32'h0,        1'b1, 32'hFFFFFFFF,  1'b0, 1'b0, 4'b1111, 32'h4,       32'h0,        1'b0, 32'hAABBCCDD,  1'b0, 32'hDEADBEEF,  1'b0, 1'b0, 1'b0};
        vec[15] = '{1'b0, 32'h0,       1'b1, 1'b0, 4'b1111, 32'h300,     32'h0,        1'b0, 32'h0,         1'b1, 1'b0, 4'b1111, 32'h300,     32'h0,        1'b0, 32'hAABBCCDD,  1'b0, 32'hDEADBEEF,  1'b0, 1'b1, 1'b1};
        vec[16] = '{1'b0, 32'h0,       1'b1, 1'b0, 4'b1111, 32'h300,     32'h0,        1'b1, 32'h11223344,  1'b0, 1'b0, 4'b1111, 32'h300,     32'h0,        1'b0, 32'hAABBCCDD,  1'b1, 32'h11223344,  1'b0, 1'b0, 1'b0};
        vec[17] = '{1'b0, 32'h0,       1'b1, 1'b0, 4'b1111, 32'h300,     32'h0,        1'b0, 32'h0,         1'b0, 1'b0, 4'b1111, 32'h300,     32'h0,        1'b0, 32'hAABBCCDD,  1'b0, 32'h11223344,  1'b0, 1'b0, 1'b1};
        vec[18] = '{1'b0, 32'h0,       1'b0, 1'b0, 4'b1111, 32'h0,       32'h0,        1'b0, 32'h0,         1'b0, 1'b0, 4'b1111, 32'h300,     32'h0,        1'b0, 32'hAABBCCDD,  1'b0, 32'h11223344,  1'b0, 1'b0, 1'b0};

        reset_n = 1'b0;
        drive(vec[18]);
        repeat (2) @(posedge clk);
        #1;
        check_reset("por");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vec[i]);
            @(posedge clk);
            #1;
            check_vec(i, vec[i]);
        end

        // Watchdog: load that never sees bus_ack.
        @(negedge clk);
        d_ce = 1'b1; d_we = 1'b0; d_sel = 4'b0000; d_addr = 32'h400; bus_ack = 1'b0;
        @(posedge clk);
        #1;
        check("wd bus_ce rise", 32'(bus_ce), 32'd1);
        n = 0;
        fired = 1'b0;
        while (!fired && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus_err) fired = 1'b1;
        end
        check("wd latency", 32'(n), 32'd16);
        check("wd d_ready", 32'(d_ready), 32'd1);
        check("wd d_rdata", d_rdata, 32'h0);
        check("wd bus_ce", 32'(bus_ce), 32'd0);
        check("wd grant_d", 32'(grant_d), 32'd0);
        @(negedge clk);
        d_ce = 1'b0;
        @(posedge clk);
        #1;
        check("wd err pulse", 32'(bus_err), 32'd0);
        check("wd ready pulse", 32'(d_ready), 32'd0);
        check("wd idle bus_ce", 32'(bus_ce), 32'd0);

        // Reset during a fetch, then a fresh fetch once released.
        @(negedge clk);
        if_ce = 1'b1; if_addr = 32'h8;
        @(posedge clk);
        #1;
        check("rst fetch bus_ce", 32'(bus_ce), 32'd1);
        check("rst fetch addr", bus_addr, 32'h8);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset("mid");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("refetch bus_ce", 32'(bus_ce), 32'd1);
        check("refetch addr", bus_addr, 32'h8);
        check("refetch if_ready", 32'(if_ready), 32'd0);
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'h0BADF00D;
        @(posedge clk);
        #1;
        check("refetch done", 32'(if_ready), 32'd1);
        check("refetch rdata", if_rdata, 32'h0BADF00D);
        @(negedge clk);
        if_ce = 1'b0; bus_ack = 1'b0;
        @(posedge clk);
        #1;
        check("refetch pulse", 32'(if_ready), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single external memory port between instruction fetch (IF) and the load/store path of the mem stage. Data requests have priority.
- Each accepted request is registered onto the bus and held stable until the memory acknowledges or a watchdog expires.
- Results are returned to the winning requester, and a stall request goes to ctrl while any requester waits.
- Sits between if/mem stages and the SRAM/bus interface.

Parameters:
TIMEOUT, 16, max cycles a bus transaction may wait for bus_ack before aborting (must be >=2)
CNT_W, 5, width of the watchdog counter (2^CNT_W > TIMEOUT)

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  synchronous active-low reset
if_ce  input  1  instruction fetch request (read only)
if_addr  input  32  fetch address, word aligned
if_rdata  output  32  fetched instruction
if_ready  output  1  one-cycle pulse: if_rdata valid
d_ce  input  1  data request from mem stage
d_we  input  1  1=store, 0=load
d_sel  input  4  byte enables, ACTIVE LOW (4'b0000 = full word, 4'b0111 = byte lane 31:24)
d_addr  input  32  data address
d_wdata  input  32  store data, lanes pre-replicated by mem stage
d_rdata  output  32  load data, raw word
d_ready  output  1  one-cycle pulse: data access complete
bus_ce  output  1  bus request
bus_we  output  1  bus write
bus_sel  output  4  byte enables, active low
bus_addr  output  32  bus address
bus_wdata  output  32  bus write data
bus_rdata  input  32  bus read data, valid with bus_ack
bus_ack  input  1  transaction complete
bus_err  output  1  one-cycle pulse: watchdog abort
stall_req  output  1  to ctrl: freeze pipeline
grant_d  output  1  1 while the current bus owner is the data path

Behaviour:
- Reset (reset_n=0 at a clock edge), all outputs and state take these values:
  - bus_ce=0, bus_we=0, bus_sel=4'b1111, bus_addr=0, bus_wdata=0
  - if_ready=0, d_ready=0, if_rdata=0, d_rdata=0, bus_err=0, grant_d=0
  - state=IDLE, watchdog counter=0
- Reset mid-transaction aborts it; no ready pulse is generated.
- FSM states: IDLE, D_BUSY, I_BUSY.
- IDLE:
  - If d_ce=1: go to D_BUSY. Register bus_ce=1, bus_we=d_we, bus_sel=d_sel, bus_addr=d_addr, bus_wdata=d_wdata. Set grant_d=1.
  - Else if if_ce=1: go to I_BUSY. Register bus_ce=1, bus_we=0, bus_sel=4'b0000, bus_addr=if_addr, bus_wdata=0. Set grant_d=0.
  - Data wins a simultaneous request.
- D_BUSY / I_BUSY:
  - Bus outputs are held constant.
  - The counter increments each cycle while bus_ack=0.
- Completion (bus_ack=1):
  - Next edge: bus_ce=0, bus_we=0, bus_sel=4'b1111, return to IDLE.
  - Owner's ready pulses for exactly one cycle; its rdata latches bus_rdata.
  - On a write, d_rdata is unchanged.
- Watchdog: when the counter reaches TIMEOUT-1 with bus_ack=0:
  - Abort, pulse bus_err and the owner's ready, latch rdata=32'h0, return to IDLE.
- Minimum latency: request seen in IDLE at cycle N, bus_ce at N+1, bus_ack at N+1, ready at N+2. One idle bus cycle separates consecutive transactions.
- rdata registers hold their value until the next completion for the same requester.
- stall_req (combinational):
  - High when (d_ce & ~(d_ready)) | (if_ce & ~(if_ready)).
  - Requesters keep ce and inputs stable while stalled.
  - A request sampled in IDLE is captured; input changes afterwards are ignored until completion.
- Starvation: after a data transaction completes, if if_ce and d_ce are both high in IDLE, data still wins. The mem stage's request falls once d_ready stalls release, so IF is served next.
- bus_ack while in IDLE is ignored.
- d_sel=4'b1111 with d_ce=1 (misaligned access from mem stage) is still issued on the bus with no lanes enabled. It completes normally.

Decomposition:
- Shared package cpu_defs: state encoding (IDLE=2'd0, D_BUSY=2'd1, I_BUSY=2'd2), SEL_NONE=4'b1111, SEL_WORD=4'b0000.
- One natural sub-module: bus_watchdog (counter, clear on start/ack, expire pulse at TIMEOUT-1), instantiated once.

Test Plan:
- Single load: d_ce=1, d_we=0, d_sel=0000, d_addr=32'h100; bus_ack after 2 cycles with bus_rdata=32'hDEADBEEF -> bus_addr=32'h100 held 3 cycles, d_ready pulses once, d_rdata=32'hDEADBEEF, stall_req high until d_ready.
- Simultaneous requests: if_ce=1 (if_addr=32'h0) and d_ce=1 (sb, d_sel=1011, d_wdata=32'h5A5A5A5A, d_addr=32'h201) same cycle, ack=1 cycle -> data transaction first (bus_we=1, bus_sel=1011), then fetch at 32'h0. if_ready follows d_ready by ≥2 cycles.
- Fetch, zero wait: if_ce=1 at 32'h4, bus_ack immediate -> bus_ce high exactly 1 cycle, if_ready at N+2, if_rdata=bus_rdata.
- Watchdog: TIMEOUT=16, d_ce load, bus_ack never -> bus_err and d_ready pulse together 16 cycles after bus_ce rises, d_rdata=0, state IDLE.
- Reset mid-operation: reset_n=0 during I_BUSY -> next edge all outputs at reset values, no if_ready. After release with if_ce still high, a fresh fetch is issued.
- Spurious ack: bus_ack=1 in IDLE with no requests -> no ready pulse, bus_ce stays 0.
